runway_allocator: RTL

RUNWAY_ALLOCATOR -- requirements
Module: runway_allocator

---
 rtl/atc_pkg.sv | 19 +
 rtl/runway_allocator_if.sv | 33 +++
 rtl/runway_slot.sv | 55 +++++
 rtl/runway_allocator.sv | 94 +++++++++
 4 files changed

// File: rtl/atc_pkg.sv
// Shared types for the runway allocator: slot state and lock response record.
package atc_pkg;

    // Width of the runway index in the response record; 3 bits covers up to 8 runways.
    localparam int RUNWAY_IDX_W = 3;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_OCC     = 2'd1,
        SLOT_OVERDUE = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic                    ack;
        logic                    ok;
        logic [RUNWAY_IDX_W-1:0] runway;
    } lock_resp_t;

endpackage

// File: rtl/runway_allocator_if.sv
// Request/response bundle between the traffic controller and the runway allocator.
interface runway_allocator_if #(
    parameter int NUM_RUNWAYS = 2,
    parameter int ID_WIDTH    = 4
) ();
    localparam int RW = $clog2(NUM_RUNWAYS);

    logic                   lock_req;
    logic [ID_WIDTH-1:0]    lock_id;
    logic                   unlock_req;
    logic [ID_WIDTH-1:0]    unlock_id;
    logic [NUM_RUNWAYS-1:0] closed_mask;
    logic                   lock_ack;
    logic                   lock_ok;
    logic [RW-1:0]          lock_runway;
    logic                   unlock_ack;
    logic                   unlock_ok;
    logic [NUM_RUNWAYS-1:0] runway_active;
    logic [NUM_RUNWAYS-1:0] runway_overdue;
    logic                   all_busy;

    modport master (
        output lock_req, lock_id, unlock_req, unlock_id, closed_mask,
        input  lock_ack, lock_ok, lock_runway, unlock_ack, unlock_ok,
               runway_active, runway_overdue, all_busy
    );

    modport slave (
        input  lock_req, lock_id, unlock_req, unlock_id, closed_mask,
        output lock_ack, lock_ok, lock_runway, unlock_ack, unlock_ok,
               runway_active, runway_overdue, all_busy
    );
endinterface

// File: rtl/runway_slot.sv
// One runway slot: occupancy state, holder id, occupancy counter and id compares.
module runway_slot
    import atc_pkg::*;
#(
    parameter int ID_WIDTH = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_grant,
    input  logic                i_release,
    input  logic [ID_WIDTH-1:0] i_lock_id,
    input  logic [ID_WIDTH-1:0] i_unlock_id,
    output logic                o_free,
    output logic                o_overdue,
    output logic                o_lock_hit,
    output logic                o_unlock_hit
);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    slot_state_e         r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_inc;

    assign w_cnt_inc = r_cnt + 16'd1;

    // Slot state machine: grant, release, and saturating occupancy count.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SLOT_FREE;
            r_id    <= '0;
            r_cnt   <= '0;
        end else if (i_grant) begin
            r_state <= SLOT_OCC;
            r_id    <= i_lock_id;
            r_cnt   <= '0;
        end else if (i_release) begin
            r_state <= SLOT_FREE;
            r_cnt   <= '0;
        end else if (r_state != SLOT_FREE && r_cnt != TIMEOUT_CNT) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == TIMEOUT_CNT) begin
                r_state <= SLOT_OVERDUE;
            end
        end
    end

    assign o_free       = (r_state == SLOT_FREE);
    assign o_overdue    = (r_state == SLOT_OVERDUE);
    assign o_lock_hit   = !o_free && (r_id == i_lock_id);
    assign o_unlock_hit = !o_free && (r_id == i_unlock_id);

endmodule

// File: rtl/runway_allocator.sv
// Runway allocator: lowest-index grant among free open runways, id-matched release,
// registered lock/unlock responses and combinational status decodes.
module runway_allocator
    import atc_pkg::*;
#(
    parameter int NUM_RUNWAYS = 2,
    parameter int ID_WIDTH    = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    runway_allocator_if.slave bus
);
    localparam int RW = $clog2(NUM_RUNWAYS);

    logic [NUM_RUNWAYS-1:0]  w_free;
    logic [NUM_RUNWAYS-1:0]  w_overdue;
    logic [NUM_RUNWAYS-1:0]  w_lock_hit;
    logic [NUM_RUNWAYS-1:0]  w_unlock_hit;
    logic [NUM_RUNWAYS-1:0]  w_free_open;
    logic [NUM_RUNWAYS-1:0]  w_grant;
    logic [NUM_RUNWAYS-1:0]  w_release;
    logic [RUNWAY_IDX_W-1:0] w_grant_idx;
    logic                    w_grant_ok;
    lock_resp_t              w_lock_next;
    lock_resp_t              r_lock_resp;
    logic                    r_unlock_ack;
    logic                    r_unlock_ok;

    for (genvar g = 0; g < NUM_RUNWAYS; g++) begin : g_slot
        runway_slot #(
            .ID_WIDTH (ID_WIDTH),
            .TIMEOUT  (TIMEOUT)
        ) u_slot (
            .clock        (clock),
            .reset_n      (reset_n),
            .i_grant      (w_grant[g]),
            .i_release    (w_release[g]),
            .i_lock_id    (bus.lock_id),
            .i_unlock_id  (bus.unlock_id),
            .o_free       (w_free[g]),
            .o_overdue    (w_overdue[g]),
            .o_lock_hit   (w_lock_hit[g]),
            .o_unlock_hit (w_unlock_hit[g])
        );
    end

    // Candidates use pre-edge state, so a slot released this cycle is never re-granted now.
    assign w_free_open = w_free & ~bus.closed_mask;
    assign w_grant_ok  = bus.lock_req && !(|w_lock_hit) && (|w_free_open);
    assign w_release   = {NUM_RUNWAYS{bus.unlock_req}} & w_unlock_hit;

    // Priority encoder: lowest-index free open runway, one-hot grant vector.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_grant_idx = '0;
        w_grant     = '0;
        for (int i = NUM_RUNWAYS - 1; i >= 0; i--) begin
            if (w_free_open[i]) begin
                w_grant_idx = RUNWAY_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_RUNWAYS; i++) begin
            w_grant[i] = w_grant_ok && (w_grant_idx == RUNWAY_IDX_W'(i));
        end
    end

    assign w_lock_next.ack    = bus.lock_req;
    assign w_lock_next.ok     = w_grant_ok;
    assign w_lock_next.runway = w_grant_ok ? w_grant_idx : '0;

    // Response registers: one-cycle ack pulses with their qualifiers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_resp  <= '0;
            r_unlock_ack <= 1'b0;
            r_unlock_ok  <= 1'b0;
        end else begin
            r_lock_resp  <= w_lock_next;
            r_unlock_ack <= bus.unlock_req;
            r_unlock_ok  <= bus.unlock_req && (|w_unlock_hit);
        end
    end

    assign bus.lock_ack       = r_lock_resp.ack;
    assign bus.lock_ok        = r_lock_resp.ok;
    assign bus.lock_runway    = RW'(r_lock_resp.runway);
    assign bus.unlock_ack     = r_unlock_ack;
    assign bus.unlock_ok      = r_unlock_ok;
    assign bus.runway_active  = ~w_free;
    assign bus.runway_overdue = w_overdue;
    assign bus.all_busy       = ~(|w_free_open);

endmodule
